// File: rtl/mod_arith_pkg.sv
// Shared encodings for the modular arithmetic units (add/sub pipe, Fp2 scheduler).
package mod_arith_pkg;

  localparam int WORD_SIZE = 4;

  typedef logic [1:0] op_t;

  localparam op_t OP_ADD = 2'b00;
  localparam op_t OP_SUB = 2'b01;
  localparam op_t OP_NEG = 2'b10;
  localparam op_t OP_DBL = 2'b11;

endpackage

// File: rtl/mod_addsub_core.sv
// Combinational dual-path modular add/subtract: computes the raw result and its
// p-corrected twin in parallel, then picks the one that lands in [0, p).
module mod_addsub_core #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] p,
  input  logic             issub,
  output logic [WIDTH-1:0] res
);

  localparam int W1 = WIDTH + 1;

  logic [W1-1:0] xe, ye, pe;
  logic [W1-1:0] org, alt, sel;
  logic [W1-1:0] y_term, p_term;
  logic [W1-1:0] cs_sum, cs_maj, cs_carry;

  assign xe = {1'b0, x};
  assign ye = {1'b0, y};
  assign pe = {1'b0, p};

  assign org = issub ? (xe - ye) : (xe + ye);

  // alt = x - y + p (sub) or x + y - p (add); both negations share the same +1 carry-in.
  assign y_term   = issub ? ~ye : ye;
  assign p_term   = issub ? pe  : ~pe;
  assign cs_sum   = xe ^ y_term ^ p_term;
  assign cs_maj   = (xe & y_term) | (xe & p_term) | (y_term & p_term);
  assign cs_carry = {cs_maj[W1-2:0], 1'b0};
  assign alt      = cs_sum + cs_carry + W1'(1);

  // The top bit acts as the sign of the W+1-bit difference in either path.
  assign sel = issub ? (org[WIDTH] ? alt : org)
                     : (alt[WIDTH] ? org : alt);

  assign res = sel[WIDTH-1:0];

endmodule

// File: rtl/mod_addsub_pipe.sv
// Two-stage streaming modular add/sub/negate/double unit with valid/ready
// handshake, runtime modulus and a pass-through tag.
import mod_arith_pkg::*;

module mod_addsub_pipe #(
  parameter int WIDTH = 2 * WORD_SIZE,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_p,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_x, s1_y, s1_p;
  logic             s1_issub;
  logic [TAG_W-1:0] s1_tag;

  logic [WIDTH-1:0] prep_x, prep_y;
  logic             prep_sub;
  logic [WIDTH-1:0] core_res;
  logic             s2_adv, s1_adv;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = s1_valid && s2_adv;
  assign in_ready = !s1_valid || s2_adv;
  assign busy     = s1_valid || out_valid;

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    prep_x   = in_a;
    prep_y   = in_b;
    prep_sub = 1'b0;
    case (in_op)
      OP_SUB: prep_sub = 1'b1;
      OP_NEG: begin
        prep_x   = '0;
        prep_y   = in_a;
        prep_sub = 1'b1;
      end
      OP_DBL:  prep_y = in_a;
      default: ;
    endcase
  end

  // NOTE: datapath registers are reset too, because out_res/out_tag must read 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_p     <= '0;
      s1_issub <= 1'b0;
      s1_tag   <= '0;
    end else if (clr) begin
      s1_valid <= 1'b0;
    end else if (in_ready) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_x     <= prep_x;
        s1_y     <= prep_y;
        s1_p     <= in_p;
        s1_issub <= prep_sub;
        s1_tag   <= in_tag;
      end
    end
  end

  mod_addsub_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .x     (s1_x),
    .y     (s1_y),
    .p     (s1_p),
    .issub (s1_issub),
    .res   (core_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_res   <= '0;
      out_tag   <= '0;
    end else if (clr) begin
      out_valid <= 1'b0;
      out_res   <= '0;
      out_tag   <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_adv) begin
        out_res <= core_res;
        out_tag <= s1_tag;
      end
    end
  end

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// Directed and randomised self-check of mod_addsub_pipe at WIDTH=8.
module tb_mod_addsub_pipe;
  import mod_arith_pkg::*;

  localparam int WIDTH = 8;
  localparam int TAG_W = 4;

  logic             clk, rst_n, clr;
  logic             in_valid, in_ready, out_valid, out_ready, busy;
  op_t              in_op;
  logic [WIDTH-1:0] in_a, in_b, in_p, out_res;
  logic [TAG_W-1:0] in_tag, out_tag;

  int errors = 0;
  int checks = 0;
  int sent, recv, tag_cnt;
  int rp, ra, rb;
  op_t rop;
  logic held;
  logic [WIDTH-1:0] held_res;
  logic [TAG_W-1:0] held_tag;
  int exp_q[$];
  int tag_q[$];
  int e_res, e_tag;

  mod_addsub_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_p      (in_p),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_tag   (out_tag),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int model(input op_t op, input int a, input int b, input int p);
    case (op)
      OP_ADD:  return (a + b) % p;
      OP_SUB:  return (a - b + p) % p;
      OP_NEG:  return (p - a) % p;
      default: return (2 * a) % p;
    endcase
  endfunction

  // Presents one op on an idle pipe and checks the two-edge latency.
  task automatic single_op(input string name, input op_t op, input int a, input int b,
                           input int p, input int tag, input int exp);
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = WIDTH'(a);
    in_b     = WIDTH'(b);
    in_p     = WIDTH'(p);
    in_tag   = TAG_W'(tag);
    #1 check({name, "_in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check({name, "_early_valid"}, out_valid, 0);
    @(negedge clk);
    check({name, "_valid"}, out_valid, 1);
    check({name, "_res"}, out_res, exp);
    check({name, "_tag"}, out_tag, tag);
  endtask

  // Loads two ops so that both stages are full at the following negedge.
  task automatic fill_two();
    @(negedge clk);
    in_valid = 1'b1; in_op = OP_ADD; in_a = 8'd10; in_b = 8'd20; in_p = 8'd251; in_tag = 4'd1;
    @(negedge clk);
    in_a = 8'd30; in_b = 8'd40; in_tag = 4'd2;
    @(negedge clk);
    in_valid = 1'b0;
    #1 check("fill_busy", busy, 1);
    check("fill_out_valid", out_valid, 1);
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = OP_ADD; in_a = '0; in_b = '0; in_p = 8'd251; in_tag = '0;
    held = 1'b0; held_res = '0; held_tag = '0;

    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_res", out_res, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    single_op("add_wrap", OP_ADD, 200, 100, 251, 5, 49);
    single_op("add_eq_p", OP_ADD, 125, 126, 251, 6, 0);
    single_op("sub_neg",  OP_SUB, 3, 10, 251, 7, 244);
    single_op("sub_pos",  OP_SUB, 10, 3, 251, 8, 7);
    single_op("sub_eq",   OP_SUB, 7, 7, 251, 9, 0);
    single_op("neg_zero", OP_NEG, 0, 0, 251, 10, 0);
    single_op("neg_one",  OP_NEG, 1, 0, 251, 11, 250);
    single_op("dbl_pm1",  OP_DBL, 250, 0, 251, 12, 249);
    single_op("dbl_100",  OP_DBL, 100, 0, 251, 13, 200);

    // Eight back-to-back ADDs with the consumer stalled for cycles 3..6.
    sent = 0; recv = 0; held = 1'b0;
    for (int t = 0; t < 40 && recv < 8; t++) begin
      @(negedge clk);
      out_ready = !(t >= 3 && t <= 6);
      in_valid  = (sent < 8);
      in_op     = OP_ADD;
      in_a      = WIDTH'(30 * sent);
      in_b      = WIDTH'(20 * sent + 7);
      in_p      = 8'd251;
      in_tag    = TAG_W'(sent);
      #1;
      if (held) begin
        check("stall_hold_valid", out_valid, 1);
        check("stall_hold_res", out_res, held_res);
        check("stall_hold_tag", out_tag, held_tag);
      end
      if (t >= 3 && t <= 6) check("stall_in_ready", in_ready, 0);
      if (out_valid && out_ready) begin
        check("stream_res", out_res, (50 * recv + 7) % 251);
        check("stream_tag", out_tag, recv);
        recv++;
      end
      held     = out_valid && !out_ready;
      held_res = out_res;
      held_tag = out_tag;
      if (in_valid && in_ready) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_count", recv, 8);
    @(negedge clk);
    check("stream_drained", out_valid, 0);

    // Asynchronous reset with two ops in flight.
    fill_two();
    rst_n = 1'b0;
    #1;
    check("areset_out_valid", out_valid, 0);
    check("areset_busy", busy, 0);
    check("areset_out_res", out_res, 0);
    #1 rst_n = 1'b1;
    single_op("after_reset", OP_ADD, 200, 100, 251, 3, 49);

    // Synchronous flush with two ops in flight; an op offered alongside clr is dropped.
    fill_two();
    in_valid = 1'b1; in_op = OP_SUB; in_a = 8'd5; in_b = 8'd9; in_tag = 4'd14;
    clr = 1'b1;
    #1 check("clr_not_yet", out_valid, 1);
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0;
    check("clr_out_valid", out_valid, 0);
    check("clr_busy", busy, 0);
    @(negedge clk);
    check("clr_no_leak", out_valid, 0);
    single_op("after_clr", OP_SUB, 3, 10, 251, 4, 244);

    // Random ops, moduli and consumer back-pressure against a scoreboard.
    sent = 0; tag_cnt = 0;
    for (int cyc = 0; cyc < 60000 && (sent < 10000 || exp_q.size() > 0); cyc++) begin
      @(negedge clk);
      rp  = $urandom_range(3, 255);
      ra  = $urandom_range(0, rp - 1);
      rb  = $urandom_range(0, rp - 1);
      rop = op_t'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = (sent < 10000) && ($urandom_range(0, 4) != 0);
      in_op  = rop;
      in_a   = WIDTH'(ra);
      in_b   = WIDTH'(rb);
      in_p   = WIDTH'(rp);
      in_tag = TAG_W'(tag_cnt);
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("rand_spurious_valid", out_valid, 0);
        end else begin
          e_res = exp_q.pop_front();
          e_tag = tag_q.pop_front();
          check("rand_res", out_res, e_res);
          check("rand_tag", out_tag, e_tag);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(rop, ra, rb, rp));
        tag_q.push_back(tag_cnt);
        tag_cnt = (tag_cnt + 1) % 16;
        sent++;
      end
    end
    in_valid = 1'b0;
    check("rand_sent", sent, 10000);
    check("rand_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
